// File: rtl/alu_hs_core_if.sv
// ALU command interface: request A/B/ALU_FUN with valid/ready, registered
// result with class flags and a one-cycle OUT_VALID pulse.
interface alu_hs_core_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_FUN;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] ALU_OUT;
  logic             OUT_VALID;
  logic             Arith_Flag;
  logic             Logic_Flag;
  logic             CMP_Flag;
  logic             Shift_Flag;
  logic             DIV_ZERO;

  // Sequencer side: issues commands, observes results
  modport master (
    output A, B, ALU_FUN, IN_VALID,
    input  IN_READY, ALU_OUT, OUT_VALID,
    input  Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, DIV_ZERO
  );

  // ALU side: accepts commands, produces results
  modport slave (
    input  A, B, ALU_FUN, IN_VALID,
    output IN_READY, ALU_OUT, OUT_VALID,
    output Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, DIV_ZERO
  );
endinterface

// File: rtl/alu_hs_core.sv
// Clocked ALU with valid/ready command handshake. Single-cycle ops load the
// result at the accepting edge; non-zero division runs a restoring divider
// for WIDTH cycles with IN_READY low.
// Optional feature macro: ALU_MUL_EN (enables the 0010 multiply).
module alu_hs_core #(
  parameter int unsigned WIDTH = 16
) (
  input logic          CLK,
  input logic          RST,
  alu_hs_core_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, DIV = 1'b1} state_t;

  state_t           state;
  logic             ready_q;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic [3:0]       flags_q;     // {arith, logic, cmp, shift}
  logic             dz_q;
  logic [WIDTH-1:0] dvd_q;       // dividend in, quotient bits shift in at LSB
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] res_c;
  logic [3:0]       flags_c;
  logic             dz_c;
  logic [WIDTH:0]   trial_c;
  logic             qbit_c;
  logic [WIDTH-1:0] rem_nxt_c;
  logic [WIDTH-1:0] quot_c;

  // Single-cycle result and class flags for the command on the bus
  always_comb begin
    res_c   = '0;
    flags_c = 4'b0000;
    dz_c    = 1'b0;
    case (bus.ALU_FUN)
      4'h0: begin res_c = bus.A + bus.B; flags_c = 4'b1000; end
      4'h1: begin res_c = bus.A - bus.B; flags_c = 4'b1000; end
`ifdef ALU_MUL_EN
      4'h2: begin res_c = WIDTH'(bus.A * bus.B); flags_c = 4'b1000; end
`endif
      4'h3: begin
        if (bus.B == '0) begin
          res_c   = '1;
          flags_c = 4'b1000;
          dz_c    = 1'b1;
        end
      end
      4'h4: begin res_c = bus.A & bus.B;    flags_c = 4'b0100; end
      4'h5: begin res_c = bus.A | bus.B;    flags_c = 4'b0100; end
      4'h6: begin res_c = ~(bus.A & bus.B); flags_c = 4'b0100; end
      4'h7: begin res_c = ~(bus.A | bus.B); flags_c = 4'b0100; end
      4'h8: begin res_c = bus.A ^ bus.B;    flags_c = 4'b0100; end
      4'h9: begin res_c = ~(bus.A ^ bus.B); flags_c = 4'b0100; end
      4'hA: begin res_c = (bus.A == bus.B) ? WIDTH'(1) : '0; flags_c = 4'b0010; end
      4'hB: begin res_c = (bus.A >  bus.B) ? WIDTH'(2) : '0; flags_c = 4'b0010; end
      4'hC: begin res_c = (bus.A <  bus.B) ? WIDTH'(3) : '0; flags_c = 4'b0010; end
      4'hD: begin res_c = bus.A >> 1; flags_c = 4'b0001; end
      4'hE: begin res_c = bus.A << 1; flags_c = 4'b0001; end
      default: begin res_c = '0; flags_c = 4'b0000; end
    endcase
  end

  // One restoring-division step: trial subtract of the shifted remainder
  always_comb begin
    trial_c   = {rem_q, dvd_q[WIDTH-1]};
    qbit_c    = (trial_c >= {1'b0, dvs_q});
    rem_nxt_c = qbit_c ? WIDTH'(trial_c - {1'b0, dvs_q}) : trial_c[WIDTH-1:0];
    quot_c    = {dvd_q[WIDTH-2:0], qbit_c};
  end

  // Control FSM, divider datapath and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= 4'b0000;
      dz_q        <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.IN_VALID && ready_q) begin
            if (bus.ALU_FUN == 4'h3 && bus.B != '0) begin
              state   <= DIV;
              ready_q <= 1'b0;
              dvd_q   <= bus.A;
              dvs_q   <= bus.B;
              rem_q   <= '0;
              cnt_q   <= '0;
            end else begin
              out_q       <= res_c;
              flags_q     <= flags_c;
              dz_q        <= dz_c;
              out_valid_q <= 1'b1;
            end
          end
        end
        DIV: begin
          rem_q <= rem_nxt_c;
          dvd_q <= quot_c;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            out_q       <= quot_c;
            flags_q     <= 4'b1000;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.IN_READY   = ready_q;
  assign bus.ALU_OUT    = out_q;
  assign bus.OUT_VALID  = out_valid_q;
  assign bus.Arith_Flag = flags_q[3];
  assign bus.Logic_Flag = flags_q[2];
  assign bus.CMP_Flag   = flags_q[1];
  assign bus.Shift_Flag = flags_q[0];
  assign bus.DIV_ZERO   = dz_q;

endmodule

// File: tb/tb_alu_hs_core.sv
// Scoreboard bench for alu_hs_core: directed test-plan cases plus random
// commands against an arithmetic reference model.
module tb_alu_hs_core;

  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flags;
    logic        dz;
  } exp_t;

  logic CLK;
  logic RST;
  alu_hs_core_if #(.WIDTH(WIDTH)) bus ();

  alu_hs_core #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t held;
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] out_flags();
    return {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag};
  endfunction

  // Reference model: plain integer arithmetic, result mod 2^16
  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic [3:0] f);
    exp_t e;
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned r = 0;
    e.dz = 1'b0;
    case (f)
      4'd0: r = (ua + ub) % 65536;
      4'd1: r = (ua + 65536 - ub) % 65536;
      4'd2: begin
`ifdef ALU_MUL_EN
        r = (ua * ub) % 65536;
`else
        r = 0;
`endif
      end
      4'd3: begin
        if (ub == 0) begin r = 65535; e.dz = 1'b1; end
        else r = ua / ub;
      end
      4'd4: r = ua & ub;
      4'd5: r = ua | ub;
      4'd6: r = 65535 - (ua & ub);
      4'd7: r = 65535 - (ua | ub);
      4'd8: r = ua ^ ub;
      4'd9: r = 65535 - (ua ^ ub);
      4'd10: r = (ua == ub) ? 1 : 0;
      4'd11: r = (ua > ub) ? 2 : 0;
      4'd12: r = (ua < ub) ? 3 : 0;
      4'd13: r = ua / 2;
      4'd14: r = (ua * 2) % 65536;
      default: r = 0;
    endcase
    e.res = 16'(r);
    if (f <= 4'd3) e.flags = 4'b1000;
    else if (f <= 4'd9) e.flags = 4'b0100;
    else if (f <= 4'd12) e.flags = 4'b0010;
    else if (f <= 4'd14) e.flags = 4'b0001;
    else e.flags = 4'b0000;
`ifndef ALU_MUL_EN
    if (f == 4'd2) e.flags = 4'b0000;
`endif
    return e;
  endfunction

  // Monitor: pop on OUT_VALID, otherwise outputs must hold the last result
  always @(negedge CLK) begin
    if (!RST) begin
      held = '0;
    end else if (bus.OUT_VALID) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", {16'd0, bus.ALU_OUT}, 32'hDEAD_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("alu_out", {16'd0, bus.ALU_OUT}, {16'd0, e.res});
        check("flags", {28'd0, out_flags()}, {28'd0, e.flags});
        check("div_zero", {31'd0, bus.DIV_ZERO}, {31'd0, e.dz});
        held = e;
      end
    end else begin
      check("hold_out", {16'd0, bus.ALU_OUT}, {16'd0, held.res});
      check("hold_flags", {27'd0, out_flags(), bus.DIV_ZERO}, {27'd0, held.flags, held.dz});
    end
  end

  // Wait (bounded) for IN_READY, present one command, return #1 after accept
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] f, input bit push);
    int guard = 0;
    while (!bus.IN_READY && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (!bus.IN_READY) check("ready_timeout", 32'd0, 32'd1);
    bus.A = a;
    bus.B = b;
    bus.ALU_FUN = f;
    bus.IN_VALID = 1'b1;
    if (push && bus.IN_READY) sb.push_back(model(a, b, f));
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
  endtask

  // Divide latency: ready low for WIDTH edges, result pulse at the last one
  task automatic div_timing(input bit hold_valid);
    check("div_ready_low", {31'd0, bus.IN_READY}, 32'd0);
    if (hold_valid) begin
      bus.ALU_FUN = 4'h0;
      bus.IN_VALID = 1'b1;
    end
    for (int i = 1; i < WIDTH; i++) begin
      @(posedge CLK); #1;
      check("div_busy_ready", {31'd0, bus.IN_READY}, 32'd0);
      check("div_busy_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    end
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    check("div_done_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    check("div_done_ready", {31'd0, bus.IN_READY}, 32'd1);
  endtask

  initial begin
    RST = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.ALU_FUN = '0;
    bus.IN_VALID = 1'b0;
    #15;
    check("rst_ready", {31'd0, bus.IN_READY}, 32'd1);
    check("rst_out", {16'd0, bus.ALU_OUT}, 32'd0);
    check("rst_valid_flags", {26'd0, bus.OUT_VALID, out_flags(), bus.DIV_ZERO}, 32'd0);
    #5 RST = 1'b1;
    @(posedge CLK); #1;

    // Add, including wrap
    issue(16'd10, 16'd10, 4'h0, 1);
    check("add_pulse", {31'd0, bus.OUT_VALID}, 32'd1);
    @(posedge CLK); #1;
    check("add_pulse_end", {31'd0, bus.OUT_VALID}, 32'd0);
    issue(16'hFFFF, 16'd2, 4'h0, 1);
    issue(16'd5, 16'd6, 4'h1, 1);

    // Divide 100/5 with latency check, then divide by zero
    issue(16'd100, 16'd5, 4'h3, 1);
    div_timing(1'b0);
    issue(16'd7, 16'd0, 4'h3, 1);
    check("dz_ready", {31'd0, bus.IN_READY}, 32'd1);
    check("dz_pulse", {31'd0, bus.OUT_VALID}, 32'd1);

    // Back-to-back single-cycle ops
    issue(16'd18, 16'd10, 4'h4, 1);
    issue(16'd9, 16'd3, 4'h6, 1);
    issue(16'd40, 16'd20, 4'hB, 1);
    issue(16'd20, 16'd0, 4'hD, 1);
    issue(16'd1, 16'd2, 4'hF, 1);

    // Command held valid during a divide must be ignored
    issue(16'd1000, 16'd7, 4'h3, 1);
    div_timing(1'b1);
    @(posedge CLK); #1;

    // Multiply (enabled or unsupported depending on build)
    issue(16'd300, 16'd300, 4'h2, 1);

    // Reset mid-division: no result may follow
    issue(16'hFFFF, 16'd3, 4'h3, 0);
    repeat (8) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, bus.IN_READY}, 32'd1);
    check("mid_rst_out", {16'd0, bus.ALU_OUT}, 32'd0);
    check("mid_rst_flags", {26'd0, bus.OUT_VALID, out_flags(), bus.DIV_ZERO}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (20) @(posedge CLK);
    #1;

    // Random commands
    for (int i = 0; i < 200; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      int sel;
      a = 16'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0) b = 16'd0;
      else if (sel == 1) b = 16'($urandom_range(1, 8));
      else b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = b;
      issue(a, b, 4'($urandom_range(0, 15)), 1);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge CLK); #1;
      end
    end

    // Drain scoreboard
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check("sb_drain", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_hs_core.md
# alu_hs_core

Clocked 16-bit ALU that executes one command per valid/ready handshake and returns a registered result with one-hot class flags. Most operations complete in one cycle; division uses an iterative restoring divider and occupies the unit for WIDTH cycles. It is the responding end of the ALU command interface. A sequencer or bench issues A/B/ALU_FUN and checks ALU_OUT plus {Arith, Logic, CMP, Shift} flags.

## Interface
- WIDTH, 16, operand/result width; divider iteration count
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-low reset
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- ALU_FUN  input  4  operation code
- IN_VALID  input  1  command present
- IN_READY  output  1  unit can accept a command; reset 1
- ALU_OUT  output  WIDTH  registered result; reset 0
- OUT_VALID  output  1  one-cycle pulse marking a new result; reset 0
- Arith_Flag / Logic_Flag / CMP_Flag / Shift_Flag  output  1 each  class of the last result; reset 0
- DIV_ZERO  output  1  last result was a divide by zero; reset 0

## Operation
- Accept on a rising edge with IN_VALID && IN_READY; commands are ignored while IN_READY=0.
- Codes and classes:
  - Arith: 0000 A+B; 0001 A−B; 0010 A*B; 0011 A/B.
  - Logic: 0100 AND; 0101 OR; 0110 NAND; 0111 NOR; 1000 XOR; 1001 XNOR.
  - CMP: 1010 (A==B)?1:0; 1011 (A>B)?2:0; 1100 (A<B)?3:0.
  - Shift: 1101 A>>1, logical; 1110 A<<1.
  - 1111: result 0, all flags 0.
- Add, sub and mul are modulo 2^WIDTH: carry, borrow and high product bits are discarded. Sub wraps, so 5−6 = 16'hFFFF.
- Exactly one class flag is high per result, except code 1111 and unsupported codes, which give all flags 0.
- DIV_ZERO is high only for 0011 with B=0. That case returns ALU_OUT=16'hFFFF, Arith_Flag=1, in a single cycle.
- FSM states:
  - IDLE: IN_READY=1. A single-cycle op or divide-by-zero stays in IDLE. 0011 with B≠0 latches A and B and moves to DIV.
  - DIV: IN_READY=0. One quotient bit per cycle, MSB first, with a WIDTH-bit remainder register. After WIDTH iterations it loads the quotient and returns to IDLE. The remainder is discarded.
- ALU_OUT, flags and DIV_ZERO hold until the next result loads; only OUT_VALID pulses.

## Timing
- Single-cycle op accepted at edge k:
  - ALU_OUT, flags and OUT_VALID=1 load at edge k.
  - OUT_VALID returns to 0 at edge k+1 unless another command is accepted there.
  - Back-to-back acceptance every cycle is legal; throughput is 1/cycle.
- Divide accepted at edge k:
  - IN_READY=0 from edge k.
  - Iterations run at edges k+1..k+WIDTH.
  - Quotient, Arith_Flag and OUT_VALID load at edge k+WIDTH, and IN_READY returns to 1 at the same edge.
  - The next command can be accepted at edge k+WIDTH+1.
- While in DIV, OUT_VALID=0 and the previous result stays on ALU_OUT.
- RST low at any time, including mid-division: immediate asynchronous clear of all outputs to reset values, FSM to IDLE. The division is abandoned and no OUT_VALID is produced for it.
- First acceptance is possible at the first rising edge after RST deasserts.

## Configuration
- ALU_MUL_EN defined: 0010 produces A*B truncated to WIDTH, Arith_Flag=1.
- ALU_MUL_EN undefined:
  - No multiplier is synthesised.
  - 0010 behaves as an unsupported code: ALU_OUT=0, all flags 0, OUT_VALID still pulses, latency 1.

## Test plan
- A=10, B=10, 0000 -> next cycle ALU_OUT=20, flags {A,L,C,S}=1000, OUT_VALID one-cycle pulse; A=0xFFFF, B=2 -> ALU_OUT=1.
- A=100, B=5, 0011 -> IN_READY low for 16 cycles, ALU_OUT=20 with OUT_VALID 16 cycles after accept; A=7, B=0 -> 0xFFFF, DIV_ZERO=1, one cycle.
- Back-to-back, one per cycle: 0100 (18,10)->2; 0110 (9,3)->0xFFFE; 1011 (40,20)->2, flags 0010; 1101 (20)->10, flags 0001; 1111 -> 0, flags 0000.
- Assert IN_VALID with 0000 while a divide is in DIV -> command ignored; after the quotient, ALU_OUT matches the divide only.
- RST low at iteration 8 of 0xFFFF/3 -> all outputs 0 and IN_READY=1 immediately; no OUT_VALID after RST release.
- 0010 with A=300, B=300 -> 0x5F90 with ALU_MUL_EN defined; 0 with flags 0000 with it undefined.
